// File: rtl/scc_pkg.sv
// ---------------------------------------------------------------------------
// scc_pkg
// Shared constants for the SCC channel scheduler slice.
//   SCC_SLOT_COUNT / SCC_SLOT_IDLE : slot sequence (slots 0-4 = channels A-E,
//                                    slot 5 = idle)
//   SCC_ADR_*                      : CPU register address map
//   scc_adr_channel()              : channel index addressed by a freq write
// ---------------------------------------------------------------------------
package scc_pkg;

  localparam int unsigned SCC_SLOT_COUNT = 6;
  localparam int unsigned SCC_NUM_CH     = 5;
  localparam logic [2:0]  SCC_SLOT_IDLE  = 3'd5;

  localparam logic [3:0] SCC_ADR_FREQ_A_LO = 4'd0;
  localparam logic [3:0] SCC_ADR_FREQ_A_HI = 4'd1;
  localparam logic [3:0] SCC_ADR_FREQ_B_LO = 4'd2;
  localparam logic [3:0] SCC_ADR_FREQ_B_HI = 4'd3;
  localparam logic [3:0] SCC_ADR_FREQ_C_LO = 4'd4;
  localparam logic [3:0] SCC_ADR_FREQ_C_HI = 4'd5;
  localparam logic [3:0] SCC_ADR_FREQ_D_LO = 4'd6;
  localparam logic [3:0] SCC_ADR_FREQ_D_HI = 4'd7;
  localparam logic [3:0] SCC_ADR_FREQ_E_LO = 4'd8;
  localparam logic [3:0] SCC_ADR_FREQ_E_HI = 4'd9;
  localparam logic [3:0] SCC_ADR_MODE      = 4'd15;

  // Frequency registers sit in pairs (low byte even, high nibble odd).
  function automatic logic [2:0] scc_adr_channel(input logic [3:0] adr);
    return adr[3:1];
  endfunction

endpackage

// File: rtl/scc_frequency_register_file.sv
// ---------------------------------------------------------------------------
// scc_frequency_register_file
// Five 12-bit channel frequency registers with byte-lane writes.
//   clk_i, reset_i   : clock, synchronous active-high reset
//   wr_en_i          : one-cycle write strobe
//   wr_addr_i        : register address (0..9 are frequency lanes)
//   wr_data_i        : write data (odd address uses bits [3:0] only)
//   rd_sel_i         : channel read select; selects >= 5 read as 0
//   rd_data_o        : selected frequency, write-through (includes a write
//                      landing this cycle)
//   wr_hit_o         : one bit per channel, high when this cycle writes it
// ---------------------------------------------------------------------------
module scc_frequency_register_file
  import scc_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        wr_en_i,
  input  logic [3:0]  wr_addr_i,
  input  logic [7:0]  wr_data_i,
  input  logic [2:0]  rd_sel_i,
  output logic [11:0] rd_data_o,
  output logic [4:0]  wr_hit_o
);

  logic [11:0] freq_q [SCC_NUM_CH];
  logic [11:0] freq_d [SCC_NUM_CH];
  logic        lane_valid_s;

  assign lane_valid_s = wr_en_i && (wr_addr_i <= SCC_ADR_FREQ_E_HI);

  // Byte-lane write decode and per-channel hit vector.
  always_comb begin
    wr_hit_o = 5'd0;
    for (int ch = 0; ch < SCC_NUM_CH; ch++) begin
      freq_d[ch] = freq_q[ch];
      if (lane_valid_s && (scc_adr_channel(wr_addr_i) == 3'(ch))) begin
        wr_hit_o[ch] = 1'b1;
        if (wr_addr_i[0]) begin
          freq_d[ch][11:8] = wr_data_i[3:0];
        end else begin
          freq_d[ch][7:0] = wr_data_i;
        end
      end else begin
        wr_hit_o[ch] = 1'b0;
      end
    end
  end

  // Read port looks at the next-state value so a write is visible the very
  // next time its slot is entered, even when that is the following cycle.
  always_comb begin
    case (rd_sel_i)
      3'd0:    rd_data_o = freq_d[0];
      3'd1:    rd_data_o = freq_d[1];
      3'd2:    rd_data_o = freq_d[2];
      3'd3:    rd_data_o = freq_d[3];
      3'd4:    rd_data_o = freq_d[4];
      default: rd_data_o = 12'd0;
    endcase
  end

  // Frequency register storage.
  always_ff @(posedge clk_i) begin
    for (int ch = 0; ch < SCC_NUM_CH; ch++) begin
      if (reset_i) begin
        freq_q[ch] <= 12'd0;
      end else begin
        freq_q[ch] <= freq_d[ch];
      end
    end
  end

endmodule

// File: rtl/scc_channel_scheduler.sv
// ---------------------------------------------------------------------------
// scc_channel_scheduler
// Slot sequencer and register front-end for the 5-channel SCC tone generator.
//   clk, reset              : clock (one slot per cycle), sync active-high reset
//   reg_write/address/data  : CPU register write port
//   active                  : current slot 0..5 (5 = idle)
//   address_reset           : high while active == 5
//   reg_frequency_count     : frequency of the active channel, 0 in slot 5
//   reg_wave_reset          : mode bit (reg_data[5] written at address 15)
//   clear_counter_a..e      : per-channel counter-clear strobes
// Build option: SCC_DEFERRED_CLEAR_EN
//   defined   - a pending clear is issued only in its own channel's slot
//   undefined - a pending clear is issued the cycle after the write
// ---------------------------------------------------------------------------
module scc_channel_scheduler
  import scc_pkg::*;
#(
  parameter int unsigned SLOT_COUNT = SCC_SLOT_COUNT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reg_write,
  input  logic [3:0]  reg_address,
  input  logic [7:0]  reg_data,
  output logic [2:0]  active,
  output logic        address_reset,
  output logic [11:0] reg_frequency_count,
  output logic        reg_wave_reset,
  output logic        clear_counter_a,
  output logic        clear_counter_b,
  output logic        clear_counter_c,
  output logic        clear_counter_d,
  output logic        clear_counter_e
);

  localparam logic [2:0] LAST_SLOT = 3'(SLOT_COUNT - 1);

  logic [2:0]  active_q, active_d;
  logic [11:0] freq_out_q, freq_out_d;
  logic        wave_q, wave_d;
  logic [4:0]  pending_q, pending_d;
  logic [4:0]  issue_s;
  logic [4:0]  wr_hit_s;
  logic [11:0] rd_data_s;

  scc_frequency_register_file u_regs (
    .clk_i     (clk),
    .reset_i   (reset),
    .wr_en_i   (reg_write),
    .wr_addr_i (reg_address),
    .wr_data_i (reg_data),
    .rd_sel_i  (active_d),
    .rd_data_o (rd_data_s),
    .wr_hit_o  (wr_hit_s)
  );

  // Next slot; any out-of-range value folds back to slot 0.
  always_comb begin
    if (active_q >= LAST_SLOT) begin
      active_d = 3'd0;
    end else begin
      active_d = active_q + 3'd1;
    end
  end

  // Output frequency follows the next slot; the register file returns 0
  // for the idle slot.
  always_comb begin
    freq_out_d = rd_data_s;
  end

  // Mode bit: only bit 5 of a write to the mode address is kept.
  always_comb begin
    if (reg_write && (reg_address == SCC_ADR_MODE)) begin
      wave_d = reg_data[5];
    end else begin
      wave_d = wave_q;
    end
  end

  // Clear issue: from registered state only, so the strobes line up with
  // the active slot the tone generator sees on the same edge.
  always_comb begin
    issue_s = 5'd0;
`ifdef SCC_DEFERRED_CLEAR_EN
    for (int ch = 0; ch < SCC_NUM_CH; ch++) begin
      if (pending_q[ch] && (active_q == 3'(ch))) begin
        issue_s[ch] = 1'b1;
      end else begin
        issue_s[ch] = 1'b0;
      end
    end
`else
    issue_s = pending_q;
`endif
  end

  // A new write in the issue cycle re-arms the flag (set beats clear).
  always_comb begin
    pending_d = wr_hit_s | (pending_q & ~issue_s);
  end

  // Slot counter, output frequency, mode and pending registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      active_q   <= 3'd0;
      freq_out_q <= 12'd0;
      wave_q     <= 1'b0;
      pending_q  <= 5'd0;
    end else begin
      active_q   <= active_d;
      freq_out_q <= freq_out_d;
      wave_q     <= wave_d;
      pending_q  <= pending_d;
    end
  end

  assign active              = active_q;
  assign address_reset       = (active_q == SCC_SLOT_IDLE);
  assign reg_frequency_count = freq_out_q;
  assign reg_wave_reset      = wave_q;
  assign clear_counter_a     = issue_s[0];
  assign clear_counter_b     = issue_s[1];
  assign clear_counter_c     = issue_s[2];
  assign clear_counter_d     = issue_s[3];
  assign clear_counter_e     = issue_s[4];

endmodule
